// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Build option: define PS2_PARITY_CHECK_EN to drop bytes with bad odd parity.
package ps2_pkg;

    // Scan-code prefixes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Key codes the minesweeper datapath watches for
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_F     = 8'h2B;

    // Serial frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver.
// Synchronizes and de-glitches the raw lines, assembles start/8 data/parity/stop
// frames and delivers whole bytes or a frame error pulse.
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0]   FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT_CYCLES);

    logic [1:0]      clk_s;
    logic [1:0]      dat_s;
    logic            filt;
    logic            filt_d;
    logic [FW-1:0]   flt_cnt;
    logic            strobe;
    logic            din;

    frame_state_t    state;
    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [TO_W-1:0] to_cnt;
    logic            par_ok;

    assign din    = dat_s[1];
    assign strobe = filt_d & ~filt;

`ifdef PS2_PARITY_CHECK_EN
    logic par;
    assign par_ok = ^{shreg, par};

    // Parity bit capture, only needed when it is checked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            par <= 1'b0;
        else if (strobe && state == ST_PARITY)
            par <= din;
    end
`else
    assign par_ok = 1'b1;
`endif

    // Two-flop synchronizers for both raw lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
        end
    end

    // Clock filter: follow the synchronized clock only after FILTER_LEN agreeing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s[1] == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                filt    <= clk_s[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM with inter-strobe timeout; byte_valid/frame_err are one-cycle pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            to_cnt     <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == ST_IDLE) begin
                to_cnt <= '0;
                if (strobe && !din) begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                end
            end else if (strobe) begin
                to_cnt <= '0;
                case (state)
                    ST_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: state <= ST_STOP;
                    default: begin
                        state <= ST_IDLE;
                        if (din && par_ok) begin
                            byte_data  <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (to_cnt == TO_LIM - 1'b1) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
                to_cnt    <= '0;
            end else if (to_cnt != TO_LIM) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard scan-code receiver: frame receiver plus E0/F0 prefix decoder.
// keyCode holds the last make code until its matching break arrives.
// Build option: PS2_PARITY_CHECK_EN (see ps2_frame_rx).
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       keyExtended,
    output logic       keyValid,
    output logic       keyRelease,
    output logic       frameError
);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       ext;
    logic       brk;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Prefix decoder and registered key outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyCode     <= 8'h00;
            keyExtended <= 1'b0;
            keyValid    <= 1'b0;
            keyRelease  <= 1'b0;
            frameError  <= 1'b0;
            ext         <= 1'b0;
            brk         <= 1'b0;
        end else begin
            keyValid   <= 1'b0;
            keyRelease <= 1'b0;
            frameError <= 1'b0;
            if (frame_err) begin
                frameError <= 1'b1;
                ext        <= 1'b0;
                brk        <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (byte_data == PS2_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    if (brk) begin
                        keyRelease <= 1'b1;
                        // Only the break of the held key releases it
                        if (byte_data == keyCode && ext == keyExtended) begin
                            keyCode     <= 8'h00;
                            keyExtended <= 1'b0;
                        end
                    end else begin
                        keyCode     <= byte_data;
                        keyExtended <= ext;
                        keyValid    <= 1'b1;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

- Receives the raw PS/2 keyboard clock/data lines and decodes serial frames into scan-code events.
- Presents `keyCode` as a held level to `minesweeper_datapath`, which compares it against 8'h75, 8'h72, 8'h74, 8'h6B, 8'h5A and 8'h2B to raise its `*Pressed` flags.
- Handles the E0 (extended) and F0 (break) prefixes.
- Reports framing errors and frame timeouts.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical synchronized samples needed before the filtered `ps2_clk` changes state.
- `TIMEOUT_CYCLES`, default 50000: maximum `clk` cycles allowed between filtered falling edges inside a frame.

Ports:
- `clk` input 1: system clock. One clock domain; all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data` input 1: raw keyboard data, asynchronous to `clk`.
- `keyCode` output 8: last make code. Held until the break of that same code arrives, then 8'h00.
- `keyExtended` output 1: the current `keyCode` was preceded by E0.
- `keyValid` output 1: one-cycle pulse on every make event, including typematic repeats.
- `keyRelease` output 1: one-cycle pulse on every break event.
- `frameError` output 1: one-cycle pulse on a stop, parity or timeout error.

## Operation
Input conditioning:
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
- The filtered clock changes only after `FILTER_LEN` equal samples. It resets to 1.
- A filtered 1→0 transition is a sample strobe; it samples the synchronized data.

Frame FSM, states IDLE, DATA, PARITY, STOP:
- IDLE: a strobe with data 0 (start bit) goes to DATA with the bit counter at 0. A strobe with data 1 is ignored and the FSM stays in IDLE.
- DATA: shifts in 8 bits, LSB first. After the 8th bit, goes to PARITY.
- PARITY: captures the parity bit, then goes to STOP.
- STOP: data 1 with valid parity delivers the byte. Data 0 or a parity failure pulses `frameError` and discards the byte. Every STOP outcome returns to IDLE.
- Parity is odd: XOR of the 8 data bits and the parity bit must equal 1.
- Timeout: in any non-IDLE state, `TIMEOUT_CYCLES` cycles with no strobe cause `frameError`, a return to IDLE, and clearing of both prefix flags.

Prefix decoder, flags `ext` and `brk`, acting on each delivered byte:
- 8'hE0: set `ext`. No output.
- 8'hF0: set `brk`. No output.
- Any other byte with `brk`=1: pulse `keyRelease`. If the byte equals `keyCode` and `ext` equals `keyExtended`, clear `keyCode` to 8'h00 and `keyExtended` to 0. Then clear both flags.
- Any other byte with `brk`=0: load `keyCode` from the byte and `keyExtended` from `ext`, pulse `keyValid`, then clear both flags.
- A frame error also clears both prefix flags.

## Timing
- Reset values: `keyCode`=8'h00; `keyExtended`, `keyValid`, `keyRelease`, `frameError` all 0; both FSMs idle; both prefix flags clear; filtered clock 1.
- Strobe latency: 2 synchronizer cycles plus `FILTER_LEN` cycles after the raw falling edge.
- Make latency: `keyCode`, `keyExtended` and `keyValid` update on the `clk` edge after the stop-bit strobe. `keyValid` is high for exactly one cycle, in that same cycle.
- Break and error pulses appear in the same cycle position as the `keyValid` pulse.
- Pulses never overlap. A byte carries at most one event.
- Output widths are fixed. The bit counter is 4 bits. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates at its limit.
- Reset mid-frame discards the partial frame and the prefix flags with no output pulse.
- Consecutive frames may arrive back-to-back with no IDLE gap beyond the stop bit.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: parity is checked as described above. A mismatch pulses `frameError` and drops the byte.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is still clocked through the PARITY state but ignored. Only the stop bit and the timeout generate `frameError`.

## Structure
- Package `ps2_pkg` holds:
  - the constants `PS2_EXT`=8'hE0 and `PS2_BREAK`=8'hF0;
  - the key constants `KEY_UP`=8'h75, `KEY_DOWN`=8'h72, `KEY_RIGHT`=8'h74, `KEY_LEFT`=8'h6B, `KEY_ENTER`=8'h5A, `KEY_F`=8'h2B;
  - the frame-state typedef.
- One sub-module, `ps2_frame_rx`, contains the synchronizers, the clock filter, the frame FSM and the timeout logic. It outputs `byte_data[7:0]`, `byte_valid` and `frame_err`.
- The top level contains only the prefix decoder and the output registers.

## Test plan
- Frame E0, then 75 (each with correct odd parity and stop 1) → `keyValid` pulses once, `keyCode`=8'h75, `keyExtended`=1.
- Frames E0, F0, 75 following the previous test → `keyRelease` pulses, `keyCode`=8'h00, `keyExtended`=0.
- Make 2B, then break 5A → `keyRelease` pulses and `keyCode` remains 8'h2B.
- Frame 5A with a bad parity bit → with `PS2_PARITY_CHECK_EN` defined, `frameError` pulses and `keyCode` is unchanged; with it undefined, `keyCode`=8'h5A.
- Stop ps2_clk after 4 data bits for `TIMEOUT_CYCLES`+1 cycles → `frameError` pulses once; a following valid 6B frame gives `keyCode`=8'h6B.
- Assert `reset_n` low mid-frame, release, then send a valid 72 frame → all outputs 0 during reset; afterwards `keyCode`=8'h72 and `keyValid` pulses once.
